// File: rtl/alu_mult_sequencer.sv
// ============================================================================
// Module   : alu_mult_sequencer
// Purpose  : Iterative shift-add unsigned multiplier (low WIDTH bits) that
//            drives a shared external ALU. Optional overflow flag: MULT_OVF_EN.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module alu_mult_sequencer #(
    parameter int WIDTH  = 32,
    parameter int ALUC_W = 3
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [WIDTH-1:0]  operand_a,
    input  logic [WIDTH-1:0]  operand_b,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [WIDTH-1:0]  product,
    output logic              zero_out,
    output logic              ovf_out,
    output logic [ALUC_W-1:0] alu_control,
    output logic [WIDTH-1:0]  alu_op0,
    output logic [WIDTH-1:0]  alu_op1,
    input  logic [WIDTH-1:0]  alu_result,
    input  logic              alu_carry,
    input  logic              alu_zero
);

    localparam logic [ALUC_W-1:0] c_ALU_ADD = ALUC_W'(3'b000);
    localparam logic [ALUC_W-1:0] c_ALU_AND = ALUC_W'(3'b010);
    localparam logic [ALUC_W-1:0] c_ALU_SHL = ALUC_W'(3'b100);
    localparam logic [ALUC_W-1:0] c_ALU_SHR = ALUC_W'(3'b101);
    localparam logic [WIDTH-1:0]  c_ONE     = WIDTH'(1);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_CHECK = 3'd1,
        S_ADD   = 3'd2,
        S_SHL   = 3'd3,
        S_SHR   = 3'd4,
        S_DONE  = 3'd5
    } state_t;

    state_t           r_state;
    state_t           w_next;
    logic [WIDTH-1:0] r_acc;
    logic [WIDTH-1:0] r_mcand;
    logic [WIDTH-1:0] r_mplier;

    always_comb begin
        w_next      = r_state;
        alu_control = c_ALU_ADD;
        alu_op0     = '0;
        alu_op1     = '0;
        case (r_state)
            S_IDLE: begin
                if (in_valid) w_next = S_CHECK;
            end
            S_CHECK: begin
                if (r_mplier == '0) begin
                    w_next = S_DONE;
                end else begin
                    alu_control = c_ALU_AND;
                    alu_op0     = r_mplier;
                    alu_op1     = c_ONE;
                    w_next      = alu_zero ? S_SHL : S_ADD;
                end
            end
            S_ADD: begin
                alu_control = c_ALU_ADD;
                alu_op0     = r_acc;
                alu_op1     = r_mcand;
                w_next      = S_SHL;
            end
            S_SHL: begin
                alu_control = c_ALU_SHL;
                alu_op0     = r_mcand;
                alu_op1     = c_ONE;
                w_next      = S_SHR;
            end
            S_SHR: begin
                alu_control = c_ALU_SHR;
                alu_op0     = r_mplier;
                alu_op1     = c_ONE;
                w_next      = S_CHECK;
            end
            S_DONE: begin
                if (out_ready) w_next = S_IDLE;
            end
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state  <= S_IDLE;
            r_acc    <= '0;
            r_mcand  <= '0;
            r_mplier <= '0;
        end else begin
            r_state <= w_next;
            case (r_state)
                S_IDLE: begin
                    if (in_valid) begin
                        r_mcand  <= operand_a;
                        r_mplier <= operand_b;
                        r_acc    <= '0;
                    end
                end
                S_ADD:   r_acc    <= alu_result;
                S_SHL:   r_mcand  <= alu_result;
                S_SHR:   r_mplier <= alu_result;
                default: ;
            endcase
        end
    end

    assign in_ready  = (r_state == S_IDLE);
    assign out_valid = (r_state == S_DONE);
    assign product   = out_valid ? r_acc : '0;
    assign zero_out  = out_valid && (r_acc == '0);

`ifdef MULT_OVF_EN
    // lost: a set bit has been shifted out of the multiplicand; any later ADD
    // of that partial product means the true product no longer fits.
    logic r_lost;
    logic r_ovf;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_lost <= 1'b0;
            r_ovf  <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (in_valid) begin
                        r_lost <= 1'b0;
                        r_ovf  <= 1'b0;
                    end
                end
                S_ADD:   r_ovf  <= r_ovf | alu_carry | r_lost;
                S_SHL:   r_lost <= r_lost | r_mcand[WIDTH-1];
                default: ;
            endcase
        end
    end

    assign ovf_out = out_valid && r_ovf;
`else
    logic w_unused_carry;
    assign w_unused_carry = alu_carry;
    assign ovf_out        = 1'b0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_alu_mult_sequencer.sv
// Bench for alu_mult_sequencer: behavioural ALU model plus a scoreboard of
// expected product/flags/latency pushed on accept and popped on out_valid.
`default_nettype none

module tb_alu_mult_sequencer;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [31:0] operand_a = '0;
    logic [31:0] operand_b = '0;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [31:0] product;
    logic        zero_out;
    logic        ovf_out;
    logic [2:0]  alu_control;
    logic [31:0] alu_op0;
    logic [31:0] alu_op1;
    logic [31:0] alu_result;
    logic        alu_carry;
    logic        alu_zero;

    int checks = 0;
    int errors = 0;
    int add_count = 0;
    int bad_op_count = 0;

    typedef struct {
        logic [31:0] prod;
        logic        zero;
        logic        ovf;
        int          lat;
    } exp_t;
    exp_t sb[$];

    alu_mult_sequencer #(.WIDTH(32), .ALUC_W(3)) dut (
        .clk(clk), .reset(reset),
        .in_valid(in_valid), .in_ready(in_ready),
        .operand_a(operand_a), .operand_b(operand_b),
        .out_valid(out_valid), .out_ready(out_ready),
        .product(product), .zero_out(zero_out), .ovf_out(ovf_out),
        .alu_control(alu_control), .alu_op0(alu_op0), .alu_op1(alu_op1),
        .alu_result(alu_result), .alu_carry(alu_carry), .alu_zero(alu_zero)
    );

    always #5 clk = ~clk;

    // Reference ALU
    logic [32:0] w_sum;
    always_comb begin
        w_sum      = {1'b0, alu_op0} + {1'b0, alu_op1};
        alu_result = '0;
        alu_carry  = 1'b0;
        case (alu_control)
            3'b000: begin alu_result = w_sum[31:0]; alu_carry = w_sum[32]; end
            3'b010: alu_result = alu_op0 & alu_op1;
            3'b100: alu_result = alu_op0 << alu_op1[4:0];
            3'b101: alu_result = alu_op0 >> alu_op1[4:0];
            default: alu_result = '0;
        endcase
        alu_zero = (alu_result == '0);
    end

    always @(negedge clk) begin
        if (!reset) begin
            if (!(alu_control inside {3'b000, 3'b010, 3'b100, 3'b101})) bad_op_count++;
            if (alu_control == 3'b000 && (alu_op0 != 0 || alu_op1 != 0)) add_count++;
        end
    end

    function automatic exp_t model(input logic [31:0] a, input logic [31:0] b);
        exp_t        e;
        logic [63:0] full;
        int          iters;
        int          ones;
        full  = {32'd0, a} * {32'd0, b};
        iters = 0;
        ones  = 0;
        for (int i = 0; i < 32; i++) begin
            if (b[i]) begin
                iters = i + 1;
                ones++;
            end
        end
        e.prod = full[31:0];
        e.zero = (full[31:0] == 0);
`ifdef MULT_OVF_EN
        e.ovf  = (full[63:32] != 0);
`else
        e.ovf  = 1'b0;
`endif
        e.lat  = 3 * iters + ones + 2;
        return e;
    endfunction

    // Issue one multiply, wait for the result, hold it for 'hold' cycles, hand off.
    task automatic run_op(input logic [31:0] a, input logic [31:0] b, input int hold);
        exp_t e;
        int   cyc;
        int   busy_bad;
        sb.push_back(model(a, b));
        out_ready = (hold == 0);
        operand_a = a;
        operand_b = b;
        in_valid  = 1'b1;
        add_count = 0;
        checks++;
        if (in_ready !== 1'b1) begin
            errors++;
            $display("FAIL accept_ready a=%h b=%h in_ready=%b expected 1", a, b, in_ready);
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        cyc      = 0;
        busy_bad = 0;
        while (out_valid !== 1'b1 && cyc < 300) begin
            if (in_ready !== 1'b0) busy_bad++;
            @(posedge clk);
            #1;
            cyc++;
        end
        e = sb.pop_front();
        checks++;
        if (cyc >= 300) begin
            errors++;
            $display("FAIL timeout a=%h b=%h out_valid never rose, expected after %0d", a, b, e.lat);
            out_ready = 1'b1;
            return;
        end
        checks++;
        if (cyc + 1 != e.lat) begin
            errors++;
            $display("FAIL latency a=%h b=%h got %0d expected %0d", a, b, cyc + 1, e.lat);
        end
        checks++;
        if (product !== e.prod || zero_out !== e.zero || ovf_out !== e.ovf) begin
            errors++;
            $display("FAIL result a=%h b=%h got p=%h z=%b o=%b expected p=%h z=%b o=%b",
                     a, b, product, zero_out, ovf_out, e.prod, e.zero, e.ovf);
        end
        checks++;
        if (busy_bad != 0 || in_ready !== 1'b0) begin
            errors++;
            $display("FAIL busy_ready a=%h b=%h in_ready high %0d busy cycles, expected 0", a, b, busy_bad);
        end
        checks++;
        if (alu_control !== 3'b000 || alu_op0 !== 0 || alu_op1 !== 0) begin
            errors++;
            $display("FAIL done_alu_idle ctl=%b op0=%h op1=%h expected 000/0/0", alu_control, alu_op0, alu_op1);
        end
        for (int i = 0; i < hold; i++) begin
            @(posedge clk);
            #1;
            checks++;
            if (out_valid !== 1'b1 || product !== e.prod || in_ready !== 1'b0) begin
                errors++;
                $display("FAIL hold cyc=%0d got v=%b p=%h r=%b expected v=1 p=%h r=0",
                         i, out_valid, product, in_ready, e.prod);
            end
        end
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            errors++;
            $display("FAIL handoff got out_valid=%b in_ready=%b expected 0/1", out_valid, in_ready);
        end
    endtask

    task automatic test_reset();
        #2;
        in_valid  = 1'b1;
        operand_a = 32'd4;
        operand_b = 32'd4;
        checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0 || product !== 0 || zero_out !== 1'b0 || ovf_out !== 1'b0) begin
            errors++;
            $display("FAIL reset_state got r=%b v=%b p=%h z=%b o=%b expected 1 0 0 0 0",
                     in_ready, out_valid, product, zero_out, ovf_out);
        end
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (in_ready !== 1'b1 || alu_control !== 3'b000 || alu_op0 !== 0) begin
            errors++;
            $display("FAIL reset_ignores_accept got in_ready=%b ctl=%b op0=%h expected 1/000/0",
                     in_ready, alu_control, alu_op0);
        end
        in_valid = 1'b0;
        reset    = 1'b0;
        @(posedge clk);
        #1;
    endtask

    task automatic test_basic();
        run_op(32'd3, 32'd5, 0);
        checks++;
        if (add_count != 2) begin
            errors++;
            $display("FAIL basic_adds got %0d expected 2", add_count);
        end
    endtask

    task automatic test_zero_b();
        run_op(32'h1234, 32'd0, 0);
        checks++;
        if (add_count != 0) begin
            errors++;
            $display("FAIL zero_b_adds got %0d expected 0", add_count);
        end
    endtask

    task automatic test_wrap();
        run_op(32'hFFFF_FFFF, 32'hFFFF_FFFF, 0);
        run_op(32'h8000_0000, 32'd2, 0);
        run_op(32'h0001_0000, 32'h0001_0000, 0);
    endtask

    task automatic test_backpressure();
        run_op(32'd7, 32'd6, 5);
    endtask

    task automatic test_reset_midrun();
        operand_a = 32'd9;
        operand_b = 32'hFF;
        in_valid  = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        repeat (10) @(posedge clk);
        #1;
        reset = 1'b1;
        #1;
        checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1 || product !== 0) begin
            errors++;
            $display("FAIL midrun_reset got v=%b r=%b p=%h expected 0/1/0", out_valid, in_ready, product);
        end
        @(posedge clk);
        #1;
        reset = 1'b0;
        run_op(32'd2, 32'd3, 0);
    endtask

    task automatic test_back_to_back();
        for (int k = 0; k < 6; k++) begin
            run_op($urandom, 32'($urandom_range(0, 1023)), k % 2);
        end
        checks++;
        if (bad_op_count != 0) begin
            errors++;
            $display("FAIL alu_opcodes got %0d illegal opcodes expected 0", bad_op_count);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_zero_b();
        test_wrap();
        test_backpressure();
        test_reset_midrun();
        test_back_to_back();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
